// File: rtl/npc_wb_pkg.sv
// Shared types and constants for the writeback stage.
package npc_wb_pkg;

  localparam int unsigned FMT_W = 3;
  localparam int unsigned OFF_W = 3;
  localparam int unsigned CNT_W = 64;

  // Writeback FSM: accept in IDLE, stall in WAIT_MEM until load data returns.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  // Load funct3 encodings.
  localparam logic [FMT_W-1:0] FMT_LB  = 3'b000;
  localparam logic [FMT_W-1:0] FMT_LH  = 3'b001;
  localparam logic [FMT_W-1:0] FMT_LW  = 3'b010;
  localparam logic [FMT_W-1:0] FMT_LD  = 3'b011;
  localparam logic [FMT_W-1:0] FMT_LBU = 3'b100;
  localparam logic [FMT_W-1:0] FMT_LHU = 3'b101;
  localparam logic [FMT_W-1:0] FMT_LWU = 3'b110;
  localparam logic [FMT_W-1:0] FMT_BAD = 3'b111;

endpackage

// File: rtl/load_extend.sv
// Selects a load field at a byte offset within a memory word and extends it.
module load_extend
  import npc_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [FMT_W-1:0]      fmt_i,
  input  logic [OFF_W-1:0]      off_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] ext_data_c,
  output logic                  bad_fmt_c
);

  logic [DATA_WIDTH-1:0] shifted;

  // Move the addressed byte to bit 0, then sign- or zero-extend the field.
  always_comb begin
    shifted    = rdata_i >> {off_i, 3'b000};
    ext_data_c = '0;
    bad_fmt_c  = 1'b0;
    case (fmt_i)
      FMT_LB:  ext_data_c = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
      FMT_LH:  ext_data_c = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      FMT_LW:  ext_data_c = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      FMT_LD:  ext_data_c = shifted;
      FMT_LBU: ext_data_c = {{(DATA_WIDTH-8){1'b0}},  shifted[7:0]};
      FMT_LHU: ext_data_c = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      FMT_LWU: ext_data_c = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
      default: bad_fmt_c  = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results immediately, stalls loads until data returns.
module wb_stage
  import npc_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [FMT_W-1:0]      in_load_fmt,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  commit,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic                  proto_err
);

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  commit_q, commit_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
  logic                  ld_wen_q, ld_wen_d;
  logic [FMT_W-1:0]      ld_fmt_q, ld_fmt_d;
  logic [OFF_W-1:0]      ld_off_q, ld_off_d;

  logic [DATA_WIDTH-1:0] ext_data;
  logic                  bad_fmt;

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .fmt_i     (ld_fmt_q),
    .off_i     (ld_off_q),
    .rdata_i   (mem_rdata),
    .ext_data_c(ext_data),
    .bad_fmt_c (bad_fmt)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      commit_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ld_rd_q  <= '0;
      ld_wen_q <= 1'b0;
      ld_fmt_q <= '0;
      ld_off_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      commit_q <= commit_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ld_rd_q  <= ld_rd_d;
      ld_wen_q <= ld_wen_d;
      ld_fmt_q <= ld_fmt_d;
      ld_off_q <= ld_off_d;
    end
  end

  // Next-state and next-output logic; wen/commit pulse only after a completion.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    wen_d    = 1'b0;
    wdata_d  = wdata_q;
    commit_d = 1'b0;
    err_d    = err_q;
    ld_rd_d  = ld_rd_q;
    ld_wen_d = ld_wen_q;
    ld_fmt_d = ld_fmt_q;
    ld_off_d = ld_off_q;

    case (state_q)
      IDLE: begin
        // Load data with nothing outstanding is a protocol violation.
        if (mem_rvalid) begin
          err_d = 1'b1;
        end
        if (in_valid) begin
          if (in_is_load) begin
            ld_rd_d  = in_rd;
            ld_wen_d = in_wen;
            ld_fmt_d = in_load_fmt;
            ld_off_d = in_alu_result[OFF_W-1:0];
            state_d  = WAIT_MEM;
          end else begin
            rd_d     = in_rd;
            wen_d    = in_wen && (in_rd != '0);
            wdata_d  = in_alu_result;
            commit_d = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          rd_d     = ld_rd_q;
          commit_d = 1'b1;
          state_d  = IDLE;
          if (bad_fmt) begin
            wdata_d = '0;
            err_d   = 1'b1;
          end else begin
            wdata_d = ext_data;
            wen_d   = ld_wen_q && (ld_rd_q != '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q + CNT_W'(commit_d);
  end

  assign in_ready   = (state_q == IDLE);
  assign rd         = rd_q;
  assign wen        = wen_q;
  assign reg_wdata  = wdata_q;
  assign commit     = commit_q;
  assign retire_cnt = cnt_q;
  assign proto_err  = err_q;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of register data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, width of register index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream instruction present.
REQ-006 SHALL have port in_ready  output  1  stage accepts an instruction this cycle.
REQ-007 SHALL have port in_rd  input  ADDR_WIDTH  destination register index.
REQ-008 SHALL have port in_wen  input  1  instruction writes a register.
REQ-009 SHALL have port in_is_load  input  1  result comes from memory.
REQ-010 SHALL have port in_load_fmt  input  3  load funct3.
REQ-011 SHALL have port in_alu_result  input  DATA_WIDTH  ALU result, or load address when in_is_load is set.
REQ-012 SHALL have port mem_rvalid  input  1  load data valid.
REQ-013 SHALL have port mem_rdata  input  DATA_WIDTH  aligned 8-byte memory word.
REQ-014 SHALL have port rd  output  ADDR_WIDTH  register-file write index.
REQ-015 SHALL have port wen  output  1  register-file write enable.
REQ-016 SHALL have port reg_wdata  output  DATA_WIDTH  register-file write data.
REQ-017 SHALL have port commit  output  1  one-cycle pulse per retired instruction.
REQ-018 SHALL have port retire_cnt  output  64  count of retired instructions.
REQ-019 SHALL have port proto_err  output  1  sticky protocol or format error.

Function
REQ-020 SHALL implement a two-state FSM with states IDLE and WAIT_MEM.
REQ-021 in IDLE, in_ready SHALL be 1; in WAIT_MEM, in_ready SHALL be 0.
REQ-022 A transfer SHALL occur when in_valid and in_ready are both 1 at a posedge.
REQ-023 Non-load transfer in cycle N: rd, wen and reg_wdata SHALL present in_rd, in_wen and in_alu_result, and commit SHALL be 1, for cycle N+1 only; FSM stays in IDLE.
REQ-024 Load transfer in cycle N: the stage SHALL latch rd, wen, fmt and addr[2:0], and the FSM SHALL go to WAIT_MEM.
REQ-025 In WAIT_MEM, mem_rvalid at posedge M SHALL drive the extended data with wen/commit in cycle M+1, and the FSM SHALL return to IDLE; wait time is unbounded.
REQ-026 Load extraction SHALL select the field at byte offset addr[2:0]: fmt 000 = LB sign, 001 = LH sign, 010 = LW sign, 011 = LD, 100 = LBU, 101 = LHU, 110 = LWU zero-extended.
REQ-027 fmt 111 SHALL produce reg_wdata 0, wen 0, commit 1, and set proto_err.
REQ-028 Whenever the latched rd is 0, wen SHALL be 0 and commit SHALL still be 1.
REQ-029 wen and commit SHALL be 0 in any cycle not following a completion; rd and reg_wdata hold their last values.
REQ-030 mem_rvalid while in IDLE SHALL be ignored for data and SHALL set proto_err.
REQ-031 retire_cnt SHALL increment by 1 on each commit, wrapping from 2^64-1 to 0.
REQ-032 Back-to-back non-load transfers SHALL sustain one commit per cycle.

Reset
REQ-033 rst_n low SHALL immediately force FSM=IDLE, rd=0, wen=0, reg_wdata=0, commit=0, retire_cnt=0, proto_err=0.
REQ-034 Reset during WAIT_MEM SHALL abandon the pending load with no commit; a later mem_rvalid in IDLE sets proto_err.
REQ-035 rst_n deassertion SHALL allow in_ready=1 in the first cycle after release.

Structure
REQ-036 Package npc_wb_pkg SHALL hold the FSM state enum and the load funct3 constants.
REQ-037 Load extraction SHALL be a combinational sub-module named load_extend.

Verification
REQ-038 Non-load: in_rd=5, in_wen=1, result 0x1234 in cycle N -> cycle N+1 has wen=1, rd=5, reg_wdata=0x1234, commit=1, and retire_cnt=1 afterwards.
REQ-039 LB: addr low bits 3, mem_rdata=0x00000000_80000000 after 4 idle cycles -> in_ready=0 while waiting; data cycle+1 has reg_wdata=0xFFFFFFFF_FFFFFF80.
REQ-040 LWU: addr low bits 4, mem_rdata=0xDEADBEEF_00000000 -> reg_wdata=0x00000000_DEADBEEF.
REQ-041 in_rd=0, in_wen=1 -> wen=0, commit=1, retire_cnt increments.
REQ-042 Reset asserted mid-WAIT_MEM, then mem_rvalid -> no commit, proto_err=1, retire_cnt=0.
REQ-043 Ten back-to-back non-loads -> ten consecutive commit cycles, retire_cnt=10.
